// File: rtl/tsc_frame_reader_if.sv
// Host-side bundle between the trigger-surround cache, the frame reader and the
// downstream frame consumer.
interface tsc_frame_reader_if #(
    parameter int AW = 5
);
    logic          cd;
    logic [31:0]   trigtm;
    logic          sbf;
    logic [7:0]    dat;
    logic          dat_vld;
    logic          sd;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          frame_rdy;
    logic          frame_err;
    logic [AW:0]   byte_cnt;
    logic [7:0]    chksum;
    logic [31:0]   trig_time;
    logic          ack;

    modport master (
        output cd, trigtm, dat, dat_vld, sd, rd_addr, ack,
        input  sbf, rd_data, frame_rdy, frame_err, byte_cnt, chksum, trig_time
    );

    modport slave (
        input  cd, trigtm, dat, dat_vld, sd, rd_addr, ack,
        output sbf, rd_data, frame_rdy, frame_err, byte_cnt, chksum, trig_time
    );
endinterface

// File: rtl/tsc_frame_reader.sv
// Receives one trigger-surround cache dump into a local frame RAM, tracking byte
// count, checksum and trigger time, and holds the frame until downstream acks.
module tsc_frame_reader #(
    parameter int BUF_LEN = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    tsc_frame_reader_if.slave bus
);
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL     = (AW+1)'(BUF_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {WAIT_CD, REQ, RECV, DONE, ERR} state_t;

    state_t        state, state_nx;
    logic [AW:0]   cnt, cnt_nx;
    logic [7:0]    chk, chk_nx;
    logic [31:0]   trig, trig_nx;
    logic [TW-1:0] tmo, tmo_nx;
    logic          wr_en;
    logic [7:0]    ram [2**AW];
    logic [7:0]    rd_q;

    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        chk_nx   = chk;
        trig_nx  = trig;
        tmo_nx   = tmo;
        wr_en    = 1'b0;
        unique case (state)
            WAIT_CD: begin
                if (bus.cd) begin
                    trig_nx  = bus.trigtm;
                    cnt_nx   = '0;
                    chk_nx   = '0;
                    tmo_nx   = '0;
                    state_nx = REQ;
                end
            end
            REQ, RECV: begin
                // A byte beyond a full buffer is dropped and kills the frame.
                if (bus.dat_vld && cnt == FULL) begin
                    state_nx = ERR;
                end else begin
                    if (bus.dat_vld) begin
                        wr_en    = 1'b1;
                        cnt_nx   = cnt + 1'b1;
                        chk_nx   = chk_add(chk, bus.dat);
                        tmo_nx   = '0;
                        state_nx = RECV;
                    end
                    if (bus.sd) begin
                        state_nx = (cnt_nx == FULL) ? DONE : ERR;
                    end else if (!bus.dat_vld) begin
                        if (tmo == TMO_LAST) state_nx = ERR;
                        else                 tmo_nx   = tmo + 1'b1;
                    end
                end
            end
            DONE, ERR: begin
                if (bus.ack) state_nx = WAIT_CD;
            end
            default: state_nx = WAIT_CD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= WAIT_CD;
            cnt   <= '0;
            chk   <= '0;
            trig  <= '0;
            tmo   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            chk   <= chk_nx;
            trig  <= trig_nx;
            tmo   <= tmo_nx;
        end
    end

    // Frame RAM keeps its contents across reset; only the write is blocked.
    always_ff @(posedge clk) begin
        if (reset && wr_en) ram[cnt[AW-1:0]] <= bus.dat;
    end

    always_ff @(posedge clk) begin
        if (!reset) rd_q <= '0;
        else        rd_q <= ram[bus.rd_addr];
    end

    assign bus.sbf       = (state == REQ);
    assign bus.frame_rdy = (state == DONE);
    assign bus.frame_err = (state == ERR);
    assign bus.byte_cnt  = cnt;
    assign bus.chksum    = chk;
    assign bus.trig_time = trig;
    assign bus.rd_data   = rd_q;
endmodule

// File: tb/tb_tsc_frame_reader.sv
// Directed bench for tsc_frame_reader: frames and RAM reads are checked by a
// scoreboard monitor, handshake timing by direct checks in the driver.
module tb_tsc_frame_reader;
    typedef struct packed {
        logic        rdy;
        logic        err;
        logic [5:0]  cnt;
        logic [7:0]  chk;
        logic [31:0] trig;
    } frame_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rd_strobe = 1'b0;
    logic rd_pend = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [7:0] fb [0:40];
    frame_t frame_q [$];
    logic [7:0] rdq [$];
    frame_t exp_f;
    logic [7:0] exp_rd;
    logic presented = 1'b0;

    tsc_frame_reader_if #(.AW(5)) bus ();

    tsc_frame_reader #(.BUF_LEN(32), .AW(5), .TIMEOUT(255)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_pend <= rd_strobe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one expected frame per presentation, one value per read.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.frame_rdy || bus.frame_err) begin
                if (!presented) begin
                    if (frame_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got rdy=%0d err=%0d expected no frame",
                                 bus.frame_rdy, bus.frame_err);
                    end else begin
                        exp_f = frame_q.pop_front();
                        check("frame_rdy", 32'(bus.frame_rdy), 32'(exp_f.rdy));
                        check("frame_err", 32'(bus.frame_err), 32'(exp_f.err));
                        check("byte_cnt",  32'(bus.byte_cnt),  32'(exp_f.cnt));
                        check("chksum",    32'(bus.chksum),    32'(exp_f.chk));
                        check("trig_time", bus.trig_time,      exp_f.trig);
                    end
                end
                presented = 1'b1;
            end else begin
                presented = 1'b0;
            end
            if (rd_pend) begin
                if (rdq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_read: got 0x%0h expected nothing", bus.rd_data);
                end else begin
                    exp_rd = rdq.pop_front();
                    check("rd_data", 32'(bus.rd_data), 32'(exp_rd));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic start(input logic [31:0] t);
        bus.cd = 1'b1;
        bus.trigtm = t;
        step();
        bus.cd = 1'b0;
        check("sbf_req", 32'(bus.sbf), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit with_sd);
        bus.dat = v;
        bus.dat_vld = 1'b1;
        bus.sd = with_sd;
        step();
        bus.dat_vld = 1'b0;
        bus.sd = 1'b0;
    endtask

    task automatic stream(input int n, input bit sd_last);
        for (int i = 0; i < n; i++) begin
            send_byte(fb[i], sd_last && (i == n - 1));
            if (i == 0) check("sbf_drop", 32'(bus.sbf), 32'd0);
        end
    endtask

    task automatic send_sd();
        bus.sd = 1'b1;
        step();
        bus.sd = 1'b0;
    endtask

    task automatic wait_frame();
        int k = 0;
        while (!(bus.frame_rdy || bus.frame_err) && k < 16) begin
            step();
            k++;
        end
        check("frame_presented", 32'(bus.frame_rdy | bus.frame_err), 32'd1);
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        check("ack_rdy_clr", 32'(bus.frame_rdy), 32'd0);
        check("ack_err_clr", 32'(bus.frame_err), 32'd0);
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] e);
        bus.rd_addr = a;
        rd_strobe = 1'b1;
        rdq.push_back(e);
        step();
        rd_strobe = 1'b0;
    endtask

    task automatic fill_seq(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) fb[i] = base + 8'(i);
    endtask

    initial begin
        bus.cd = 1'b0;
        bus.trigtm = '0;
        bus.dat = '0;
        bus.dat_vld = 1'b0;
        bus.sd = 1'b0;
        bus.rd_addr = '0;
        bus.ack = 1'b0;

        // Reset state
        idle(2);
        check("rst_sbf",   32'(bus.sbf),       32'd0);
        check("rst_rdy",   32'(bus.frame_rdy), 32'd0);
        check("rst_err",   32'(bus.frame_err), 32'd0);
        check("rst_cnt",   32'(bus.byte_cnt),  32'd0);
        check("rst_chk",   32'(bus.chksum),    32'd0);
        check("rst_trig",  bus.trig_time,      32'd0);
        check("rst_rd",    32'(bus.rd_data),   32'd0);
        reset = 1'b1;
        idle(1);

        // Nominal frame 0x01..0x20, sd after last byte
        fill_seq(32, 8'h01);
        start(32'h0000_1234);
        frame_q.push_back('{1'b1, 1'b0, 6'd32, 8'h10, 32'h0000_1234});
        stream(32, 1'b0);
        send_sd();
        wait_frame();
        rd(5'd5, 8'h06);
        rd(5'd31, 8'h20);
        do_ack();

        // sd together with the last byte
        for (int i = 0; i < 32; i++) fb[i] = 8'hFF;
        start(32'hCAFE_0002);
        frame_q.push_back('{1'b1, 1'b0, 6'd32, 8'hE0, 32'hCAFE_0002});
        stream(32, 1'b1);
        wait_frame();
        do_ack();

        // Short frame of 10 bytes
        fill_seq(10, 8'h10);
        start(32'h0000_0003);
        frame_q.push_back('{1'b0, 1'b1, 6'd10, 8'hCD, 32'h0000_0003});
        stream(10, 1'b0);
        send_sd();
        wait_frame();
        do_ack();
        check("short_sbf_idle", 32'(bus.sbf), 32'd0);
        idle(2);
        check("short_stays_idle", 32'(bus.frame_err), 32'd0);

        // Overflow: 33rd byte is discarded
        fill_seq(32, 8'h40);
        fb[32] = 8'hAA;
        start(32'h0000_0004);
        frame_q.push_back('{1'b0, 1'b1, 6'd32, 8'hF0, 32'h0000_0004});
        stream(33, 1'b0);
        wait_frame();
        rd(5'd0, 8'h40);
        do_ack();

        // Timeout in REQ after 255 idle cycles
        start(32'h0000_5555);
        frame_q.push_back('{1'b0, 1'b1, 6'd0, 8'h00, 32'h0000_5555});
        idle(254);
        check("tmo_not_yet", 32'(bus.frame_err), 32'd0);
        check("tmo_sbf_held", 32'(bus.sbf), 32'd1);
        idle(1);
        check("tmo_err", 32'(bus.frame_err), 32'd1);
        check("tmo_sbf", 32'(bus.sbf), 32'd0);
        do_ack();

        // Gaps of 254 idle cycles never time out
        fill_seq(32, 8'h01);
        start(32'h0000_6666);
        idle(254);
        for (int i = 0; i < 32; i++) begin
            send_byte(fb[i], 1'b0);
            if (i < 3) idle(254);
        end
        idle(254);
        check("gap_no_err", 32'(bus.frame_err), 32'd0);
        frame_q.push_back('{1'b1, 1'b0, 6'd32, 8'h10, 32'h0000_6666});
        send_sd();
        wait_frame();
        do_ack();

        // Reset mid-frame
        fill_seq(5, 8'h70);
        start(32'h0000_7777);
        stream(5, 1'b0);
        reset = 1'b0;
        step();
        check("midrst_sbf", 32'(bus.sbf),       32'd0);
        check("midrst_cnt", 32'(bus.byte_cnt),  32'd0);
        check("midrst_err", 32'(bus.frame_err), 32'd0);
        check("midrst_chk", 32'(bus.chksum),    32'd0);
        reset = 1'b1;
        idle(1);

        // Back-to-back: cd held high across ack
        fill_seq(32, 8'h01);
        start(32'hAAAA_0001);
        frame_q.push_back('{1'b1, 1'b0, 6'd32, 8'h10, 32'hAAAA_0001});
        stream(32, 1'b0);
        send_sd();
        wait_frame();
        bus.cd = 1'b1;
        bus.trigtm = 32'hBBBB_0002;
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        check("b2b_rdy_clr", 32'(bus.frame_rdy), 32'd0);
        check("b2b_sbf_gap", 32'(bus.sbf),       32'd0);
        check("b2b_trig_old", bus.trig_time,     32'hAAAA_0001);
        step();
        bus.cd = 1'b0;
        check("b2b_sbf", 32'(bus.sbf),       32'd1);
        check("b2b_trig", bus.trig_time,     32'hBBBB_0002);
        check("b2b_cnt", 32'(bus.byte_cnt),  32'd0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        idle(3);

        check("frames_drained", 32'(frame_q.size()), 32'd0);
        check("reads_drained",  32'(rdq.size()),     32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tsc_frame_reader.md
Name: tsc_frame_reader

Overview:
- Host-side receiver for the trigger-surround cache dump.
- Waits for the cache to signal capture complete (cd), then asserts sbf to request the buffer.
- Receives the streamed bytes into a local frame RAM, latches the trigger timestamp, and computes a byte count and a modulo-256 checksum.
- Presents a complete or errored frame to downstream logic until that logic acknowledges it.

Parameters:
- BUF_LEN, 32, number of bytes in one cache dump; a frame must contain exactly this many.
- AW, 5, frame RAM address width; must satisfy 2**AW >= BUF_LEN.
- TIMEOUT, 255, maximum idle cycles allowed between sbf assertion or a byte and the next byte or sd.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- cd  in  1  cache done from the trigger-surround cache: capture complete, buffer ready to send.
- trigtm  in  32  trigger timestamp from the cache; valid while cd=1.
- sbf  out  1  send-buffer request to the cache.
- dat  in  8  streamed cache byte.
- dat_vld  in  1  dat is valid this cycle.
- sd  in  1  send done: the cache has finished streaming; single-cycle pulse.
- rd_addr  in  AW  frame RAM read address.
- rd_data  out  8  frame RAM read data; registered, 1-cycle latency.
- frame_rdy  out  1  frame complete and valid.
- frame_err  out  1  frame terminated abnormally.
- byte_cnt  out  AW+1  bytes received in the current or last frame.
- chksum  out  8  sum of received bytes mod 256.
- trig_time  out  32  trigtm latched at request time.
- ack  in  1  downstream has consumed the frame; clears frame_rdy/frame_err.

Behaviour:
- Reset (reset=0 at a rising edge):
  - State goes to WAIT_CD.
  - sbf, frame_rdy, frame_err = 0.
  - byte_cnt, chksum, trig_time, rd_data = 0.
  - Frame RAM contents are not cleared.
  - Reset mid-frame aborts immediately; sbf drops on that edge and no error is flagged.
- States: WAIT_CD, REQ, RECV, DONE, ERR.
- WAIT_CD:
  - On cd=1: latch trig_time=trigtm, clear byte_cnt and chksum, assert sbf, clear the timeout counter, go to REQ.
- REQ:
  - sbf is held high.
  - First dat_vld: go to RECV and drop sbf on the same edge.
  - sd with no bytes received: go to ERR.
- RECV:
  - sbf=0.
  - Each dat_vld writes dat to RAM[byte_cnt], increments byte_cnt, adds dat to chksum (8-bit wrap), and clears the timeout counter.
  - The first byte, accepted on the REQ->RECV edge, is handled the same way.
- Completion:
  - sd=1 with final count == BUF_LEN: go to DONE, frame_rdy=1.
  - Final count includes any byte accepted that same cycle.
  - sd=1 with final count != BUF_LEN (short frame): go to ERR.
- Overflow: dat_vld when byte_cnt == BUF_LEN and sd=0 discards the byte (no RAM write, no count or chksum update) and goes to ERR.
- Timeout:
  - Counter increments each cycle in REQ/RECV when neither dat_vld nor sd is high.
  - Reaching TIMEOUT goes to ERR.
- ERR: frame_err=1 and frame_rdy=0; byte_cnt and chksum hold the values at the failure point.
- DONE/ERR:
  - Outputs hold; cd and dat_vld are ignored.
  - ack=1 clears frame_rdy/frame_err on that edge and returns to WAIT_CD.
  - A new cd is only seen from the next cycle on.
- ack in any other state is ignored.
- rd_data = RAM[rd_addr] registered every cycle, independent of state.
- A read of an address written on the same edge returns the old value.
- Checksum: 8-bit unsigned add, carries discarded.

Test Plan:
1. Nominal frame:
   - Stimulus: reset low 2 cycles; cd=1 with trigtm=0x0000_1234; after sbf, stream bytes 0x01..0x20 (32 bytes, one per cycle); sd on the cycle after the last byte.
   - Required: sbf high only until the first byte; then frame_rdy=1, frame_err=0, byte_cnt=32, chksum=0x10, trig_time=0x1234; rd_addr=5 gives rd_data=0x06 one cycle later.
2. sd on the last byte's cycle:
   - Stimulus: 32 bytes of 0xFF with sd asserted together with byte 32.
   - Required: DONE, byte_cnt=32, chksum=0xE0.
3. Short frame:
   - Stimulus: 10 bytes, then sd.
   - Required: frame_err=1, frame_rdy=0, byte_cnt=10; after ack, back in WAIT_CD with both flags 0.
4. Overflow:
   - Stimulus: 33 dat_vld pulses without sd.
   - Required: frame_err=1, byte_cnt=32, RAM[0] unchanged by byte 33, chksum excludes byte 33.
5. Timeout:
   - Stimulus: cd, then no dat_vld for 255 cycles.
   - Required: frame_err=1 on the 255th idle cycle, sbf=0.
   - Stimulus: in RECV, bytes with gaps of 254 cycles.
   - Required: no error.
6. Reset mid-frame and back-to-back:
   - Stimulus: reset low after 5 bytes.
   - Required: next edge sbf=0, byte_cnt=0, frame_err=0.
   - Stimulus: nominal frame, ack, cd held high.
   - Required: a second frame is requested the cycle after ack with trig_time re-latched.
